// File: rtl/crc16_serial_framer.sv
// Byte-to-bit framer feeding a serial CRC-16 generator: load pulse, MSB-first data, d_finish, CRC tail hold-off.
// Optional abort input/aborted pulse enabled by defining CRC_FRAMER_ABORT_EN.
module crc16_serial_framer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TAIL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
`ifdef CRC_FRAMER_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              in_ready,
    output logic              load,
    output logic              crc_in,
    output logic              d_finish,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       frame_bits
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TAIL_W = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FINISH,
        S_TAIL
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAIL_W-1:0]   tail_q, tail_d;
    logic                in_ready_q, in_ready_d;
    logic                load_q, load_d;
    logic                crc_q, crc_d;
    logic                dfin_q, dfin_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;
    logic [15:0]         fbits_q, fbits_d;
    logic                hs;
    logic                abort_req;

    assign hs = in_valid && in_ready_q;

`ifdef CRC_FRAMER_ABORT_EN
    logic aborted_q;

    assign abort_req = abort;
    assign aborted   = aborted_q;

    // Abort only acts while a frame is loading or shifting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req && ((state_q == S_LOAD) || (state_q == S_SHIFT));
        end
    end
`else
    assign abort_req = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        tail_d     = tail_q;
        underrun_d = underrun_q;
        fbits_d    = fbits_q;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    sr_d       = in_data;
                    last_d     = in_last;
                    underrun_d = 1'b0;
                    fbits_d    = 16'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sr_d    = sr_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                fbits_d = (fbits_q == 16'hFFFF) ? fbits_q : fbits_q + 16'd1;
                if (cnt_q == BIT_LAST) begin
                    if (last_q) begin
                        state_d = S_FINISH;
                    end else if (hs) begin
                        sr_d   = in_data;
                        last_d = in_last;
                        cnt_d  = '0;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                tail_d  = '0;
                state_d = S_TAIL;
            end
            S_TAIL: begin
                tail_d = tail_q + TAIL_W'(1);
                if (tail_q == TAIL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_req && ((state_q == S_LOAD) || (state_q == S_SHIFT))) begin
            state_d = S_IDLE;
        end

        // Outputs are computed from the next state so they register in step with it
        in_ready_d = (state_d == S_IDLE) ||
                     ((state_d == S_SHIFT) && (cnt_d == BIT_LAST) && !last_d);
        load_d     = (state_d == S_LOAD);
        crc_d      = (state_d == S_SHIFT) ? sr_d[DATA_W-1] : 1'b0;
        dfin_d     = (state_d == S_FINISH);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            load_q     <= 1'b0;
            crc_q      <= 1'b0;
            dfin_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            fbits_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            load_q     <= load_d;
            crc_q      <= crc_d;
            dfin_q     <= dfin_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            fbits_q    <= fbits_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign load       = load_q;
    assign crc_in     = crc_q;
    assign d_finish   = dfin_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign frame_bits = fbits_q;

endmodule

// File: tb/tb_crc16_serial_framer.sv
// Self-checking bench for crc16_serial_framer: directed and random frames against a cycle-timeline model.
module tb_crc16_serial_framer;

    localparam int W    = 8;
    localparam int TAIL = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         load;
    logic         crc_in;
    logic         d_finish;
    logic         busy;
    logic         underrun;
    logic [15:0]  frame_bits;
`ifdef CRC_FRAMER_ABORT_EN
    logic         abort;
    logic         aborted;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] wq[$];
    int           prev_fb = 0;
    bit           prev_und = 1'b0;

    crc16_serial_framer #(.DATA_W(W), .TAIL_CYCLES(TAIL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
`ifdef CRC_FRAMER_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .in_ready   (in_ready),
        .load       (load),
        .crc_in     (crc_in),
        .d_finish   (d_finish),
        .busy       (busy),
        .underrun   (underrun),
        .frame_bits (frame_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Bit i of the frame, counting MSB-first across the word list
    function automatic logic frame_bit(input int i);
        logic [W-1:0] w;
        w = wq[i / W];
        return w[3'(W - 1 - (i % W))];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 0, 32'(in_ready), 32'd0);
        check({tag, "_load"},  0, 32'(load),     32'd0);
        check({tag, "_crc"},   0, 32'(crc_in),   32'd0);
        check({tag, "_dfin"},  0, 32'(d_finish), 32'd0);
        check({tag, "_busy"},  0, 32'(busy),     32'd0);
        check({tag, "_und"},   0, 32'(underrun), 32'd0);
        check({tag, "_fb"},    0, 32'(frame_bits), 32'd0);
    endtask

    // Run one frame of s words from wq; full=1 flags the final word as last.
    // abort_cyc is the cycle (relative to acceptance) on which abort is held high, or -1.
    task automatic run_frame(input int s, input bit full, input int abort_cyc);
        int b, end_c, widx, guard, fbx;
        bit ab;
        logic [31:0] e_load, e_crc, e_dfin, e_rdy, e_busy, e_und, e_fb, e_ab;
        b  = s * W;
        ab = (abort_cyc >= 1) && (abort_cyc <= 1 + b);
`ifndef CRC_FRAMER_ABORT_EN
        ab = 1'b0;
`endif
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_ready", guard, 32'(in_ready), 32'd1);
        end_c    = ab ? abort_cyc + 3 : 4 + b + TAIL;
        widx     = 0;
        in_valid = 1'b1;
        in_data  = wq[0];
        in_last  = full && (s == 1);
        for (int c = 0; c <= end_c; c++) begin
            if (ab && c > abort_cyc) begin
                e_load = 0; e_crc = 0; e_dfin = 0; e_rdy = 1; e_busy = 0; e_und = 0;
                e_fb = 32'(abort_cyc - 1);
                e_ab = 32'(c == abort_cyc + 1);
            end else begin
                e_load = 32'(c == 1);
                e_crc  = (c >= 2 && c <= 1 + b) ? 32'(frame_bit(c - 2)) : 32'd0;
                e_dfin = 32'(c == 2 + b);
                e_rdy  = 32'((c == 0) || (c >= 3 + b + TAIL) ||
                             (c >= 1 + W && c <= 1 + b && ((c - 1) % W) == 0 &&
                              (c != 1 + b || !full)));
                e_busy = 32'(c >= 1 && c <= 2 + b + TAIL);
                e_und  = (c == 0) ? 32'(prev_und) : 32'(c >= 2 + b && !full);
                fbx    = (c - 2 > b) ? b : c - 2;
                e_fb   = (c == 0) ? 32'(prev_fb) : (c <= 2) ? 32'd0 : 32'(fbx);
                e_ab   = 0;
            end
            check("load",       c, 32'(load),       e_load);
            check("crc_in",     c, 32'(crc_in),     e_crc);
            check("d_finish",   c, 32'(d_finish),   e_dfin);
            check("in_ready",   c, 32'(in_ready),   e_rdy);
            check("busy",       c, 32'(busy),       e_busy);
            check("underrun",   c, 32'(underrun),   e_und);
            check("frame_bits", c, 32'(frame_bits), e_fb);
`ifdef CRC_FRAMER_ABORT_EN
            check("aborted",    c, 32'(aborted),    e_ab);
`endif
            if (in_valid && in_ready) widx++;
            @(posedge clk);
            #1;
`ifdef CRC_FRAMER_ABORT_EN
            abort = (c + 1 == abort_cyc);
`endif
            if (ab && c == abort_cyc) widx = s;
            in_valid = (widx < s);
            in_last  = full && (widx == s - 1);
            if (widx < s) in_data = wq[widx];
            else          in_data = '0;
            @(negedge clk);
        end
        prev_fb  = ab ? abort_cyc - 1 : b;
        prev_und = ab ? 1'b0 : !full;
    endtask

    task automatic fill_random(input int s);
        wq.delete();
        for (int k = 0; k < s; k++) wq.push_back(W'($urandom));
    endtask

    initial begin
        int s, ac;
        bit full;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
`ifdef CRC_FRAMER_ABORT_EN
        abort    = 1'b0;
`endif
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_pre_edge", 0, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_post_edge", 0, 32'(in_ready), 32'd1);
        @(negedge clk);

        wq = '{8'hA5};
        run_frame(1, 1'b1, -1);

        wq = '{8'h12, 8'h34, 8'h56};
        run_frame(3, 1'b1, -1);

        wq = '{8'hFF};
        run_frame(1, 1'b0, -1);

        fill_random(2);
        run_frame(2, 1'b1, -1);

        // Reset asserted in the middle of a frame
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready_pre", 0, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_ready_post", 0, 32'(in_ready), 32'd1);
        check("midrst_busy_post", 0, 32'(busy), 32'd0);
        @(negedge clk);
        prev_fb  = 0;
        prev_und = 1'b0;
        wq = '{8'hA5};
        run_frame(1, 1'b1, -1);

`ifdef CRC_FRAMER_ABORT_EN
        fill_random(2);
        run_frame(2, 1'b1, 4);
        fill_random(1);
        run_frame(1, 1'b1, 3 + W + 5);
`endif

        for (int it = 0; it < 8; it++) begin
            s    = int'($urandom_range(1, 4));
            full = ($urandom_range(0, 3) != 0);
            ac   = -1;
`ifdef CRC_FRAMER_ABORT_EN
            if ($urandom_range(0, 2) == 0) ac = int'($urandom_range(1, 3 + s * W + TAIL));
`endif
            fill_random(s);
            run_frame(s, full, ac);
            repeat (int'($urandom_range(0, 3))) begin
                check("gap_ready", it, 32'(in_ready), 32'd1);
                check("gap_busy",  it, 32'(busy),     32'd0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc16_serial_framer.md
# crc16_serial_framer

Byte-to-bit framer directly upstream of the serial CRC-16 generator. Accepts parallel bytes over a valid/ready handshake and drives the generator's `load`, `crc_in` and `d_finish` inputs. It emits one `load` pulse per frame, streams the data MSB-first at one bit per clock with no gaps, and pulses `d_finish` after the last bit. It then holds off new frames for the generator's 16-cycle CRC tail.

## Interface
Parameters:
- `DATA_W`, default 8: width of each input word, in bits shifted per word.
- `TAIL_CYCLES`, default 16: cycles after `d_finish` during which the framer stays busy while the CRC remainder drains.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  word to serialise.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_last`  in  1  the current word is the last word of the frame.
- `in_ready`  out  1  framer accepts a word this cycle; driven from registers only.
- `load`  out  1  one-cycle pulse starting a frame; connects to generator `load`.
- `crc_in`  out  1  serial data bit; connects to generator `crc_in`.
- `d_finish`  out  1  one-cycle pulse after the last data bit; connects to generator `d_finish`.
- `busy`  out  1  high in every state except IDLE.
- `underrun`  out  1  sticky flag: the frame was cut short because no word was available.
- `frame_bits`  out  16  count of data bits sent in the current or most recent frame; saturates at 0xFFFF.

## Operation
- States: IDLE, LOAD, SHIFT, FINISH, TAIL.
- A handshake occurs when `in_valid && in_ready`.
- **IDLE:** `in_ready`=1.
  - On handshake, capture the word into the shift register and latch `in_last`.
  - Clear `underrun` and `frame_bits`, then go to LOAD.
- **LOAD:** `load`=1 and `crc_in`=0 for one cycle, then go to SHIFT.
- **SHIFT:** `crc_in` = shift-register MSB; the register shifts left each cycle.
  - `bit_cnt` counts 0..DATA_W-1; `frame_bits` increments each cycle.
  - `in_ready`=1 during the cycle where `bit_cnt`==DATA_W-1 and the latched `last`=0.
  - At `bit_cnt`==DATA_W-1:
    - If `last`=1, go to FINISH.
    - Else if a handshake occurs, reload the shift register and `last`, reset `bit_cnt`, and stay in SHIFT. There is no gap bit.
    - Else set `underrun`=1 and go to FINISH.
- **FINISH:** `d_finish`=1 and `crc_in`=0 for one cycle, then go to TAIL.
- **TAIL:** count TAIL_CYCLES cycles with `crc_in`=0, then return to IDLE.
- `in_ready`=0 in LOAD, in FINISH, in TAIL, and in SHIFT outside the reload cycle.
- Reset values: state=IDLE, `in_ready`=0, `load`=0, `crc_in`=0, `d_finish`=0, `busy`=0, `underrun`=0, `frame_bits`=0.
- A ready-enable flop, reset to 0, holds `in_ready` at 0 until the first rising edge after `rst` deasserts.
- Reset asserted mid-frame: all outputs go to reset values immediately. The frame is dropped and no `d_finish` is issued.
- An `in_valid` word arriving while `in_ready`=0 is held by the source and is not consumed.
- `in_last` on the final word is honoured whether that word was accepted in IDLE or in the SHIFT reload cycle.

## Timing
- Word accepted at cycle 0 in IDLE:
  - `load` at cycle 1.
  - First data bit at cycle 2.
  - For an N-word frame, the bits occupy cycles 2..1+N·DATA_W contiguously.
  - `d_finish` at cycle 2+N·DATA_W.
  - TAIL occupies cycles 3+N·DATA_W..2+N·DATA_W+TAIL_CYCLES.
  - `in_ready`=1 again at cycle 3+N·DATA_W+TAIL_CYCLES.
- For the default parameters and N=1, `in_ready` returns at cycle 27.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CRC_FRAMER_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, one-cycle pulse, reset 0).
  - `abort`=1 in LOAD or SHIFT: the next state is IDLE, `aborted` pulses, and `crc_in`=0. No `d_finish` is issued.
  - `abort` has priority over a same-cycle reload; the handshaken word is discarded.
  - `abort` is ignored in IDLE, FINISH and TAIL.
- `CRC_FRAMER_ABORT_EN` not defined: neither port exists and every frame ends through FINISH.

## Test plan
- Single word 0xA5 with `in_last`=1 -> `load` at cycle 1; `crc_in` = 1,0,1,0,0,1,0,1 on cycles 2..9; `d_finish` at cycle 10; `frame_bits`=8; `in_ready` returns at cycle 27.
- Words 0x12, 0x34, 0x56 (last), `in_valid` held high -> 24 contiguous bits with no gap; one `load`; one `d_finish` at cycle 26; `frame_bits`=24; `underrun`=0.
- Word 0xFF (not last), then `in_valid` low at the reload cycle -> `d_finish` at cycle 10; `underrun`=1; `frame_bits`=8. The next frame's acceptance clears `underrun`.
- `rst` pulled low at cycle 5 of a 0xA5 frame -> all outputs 0 asynchronously; `in_ready`=0 until the first edge after release, then a new frame starts cleanly.
- With `CRC_FRAMER_ABORT_EN` defined, `abort` at cycle 4 of a two-word frame -> `aborted` pulse, no `d_finish`, state IDLE with `in_ready`=1 the following cycle; the same `abort` pulse during TAIL has no effect.
